// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register file access controller.
// Command encodings match the RegisterFile control_signal input.
package regfile_ctrl_pkg;

    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_DATA_W       = 64;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam logic [1:0] RF_CMD_HOLD = 2'b00;
    localparam logic [1:0] RF_CMD_RD1  = 2'b01;
    localparam logic [1:0] RF_CMD_RD2  = 2'b10;
    localparam logic [1:0] RF_CMD_WR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RESP
    } ctrl_state_t;

    function automatic logic [1:0] rf_rd_cmd(input logic two);
        return two ? RF_CMD_RD2 : RF_CMD_RD1;
    endfunction

endpackage

// File: rtl/regfile_arb.sv
// Write/read priority arbiter: writes win until a waiting read has
// been passed over STARVE_LIMIT times, then one read is forced through.
module regfile_arb
    import regfile_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_req,
    input  logic rd_req,
    input  logic wr_fire,
    input  logic rd_fire,
    output logic grant_wr,
    output logic grant_rd
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          at_limit;

    assign at_limit = (starve_cnt >= CW'(STARVE_LIMIT));

    // Priority decision from the live requests and the starvation count
    always_comb begin
        grant_wr = wr_req && !(rd_req && at_limit);
        grant_rd = rd_req && !grant_wr;
    end

    // Count writes that overtook a waiting read; any read grant clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rd_fire) begin
            starve_cnt <= '0;
        end else if (wr_fire && rd_req && !at_limit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences every RegisterFile access: one op in flight, registered outputs.
// Optional feature macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic              rd_two,
    input  logic [ADDR_W-1:0] rd_rs1,
    input  logic [ADDR_W-1:0] rd_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic [1:0]        rf_cmd,
    output logic [DATA_W-1:0] rf_port1,
    output logic [DATA_W-1:0] rf_port2,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2
);

    ctrl_state_t       state, state_nxt;
    logic [1:0]        cmd_nxt;
    logic [DATA_W-1:0] p1_nxt, p2_nxt;
    logic              rsp_valid_nxt;
    logic              wr_ready_nxt, rd_ready_nxt;
    logic              two_q, two_nxt;
    logic              z1_q, z1_nxt;
    logic              z2_q, z2_nxt;
    logic              wr_fire, rd_fire;
    logic              wr_to_zero;
    logic              rs1_zero, rs2_zero;
    logic              grant_wr, grant_rd;

    assign wr_fire = wr_valid && wr_ready;
    assign rd_fire = rd_valid && rd_ready;

`ifdef REGFILE_ZERO_REG_EN
    assign wr_to_zero = (wr_addr == '0);
    assign rs1_zero   = (rd_rs1 == '0);
    assign rs2_zero   = (rd_rs2 == '0);
`else
    assign wr_to_zero = 1'b0;
    assign rs1_zero   = 1'b0;
    assign rs2_zero   = 1'b0;
`endif

    regfile_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_valid),
        .rd_req   (rd_valid),
        .wr_fire  (wr_fire),
        .rd_fire  (rd_fire),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd)
    );

    // Next state, next file command and next handshake outputs
    always_comb begin
        state_nxt     = state;
        cmd_nxt       = RF_CMD_HOLD;
        p1_nxt        = rf_port1;
        p2_nxt        = rf_port2;
        rsp_valid_nxt = 1'b0;
        two_nxt       = two_q;
        z1_nxt        = z1_q;
        z2_nxt        = z2_q;
        unique case (state)
            IDLE: begin
                if (wr_fire) begin
                    if (!wr_to_zero) begin
                        cmd_nxt   = RF_CMD_WR;
                        p1_nxt    = wr_data;
                        p2_nxt    = DATA_W'(wr_addr);
                        state_nxt = WR_ISSUE;
                    end
                end else if (rd_fire) begin
                    cmd_nxt   = rf_rd_cmd(rd_two);
                    p1_nxt    = DATA_W'(rd_rs1);
                    p2_nxt    = rd_two ? DATA_W'(rd_rs2) : '0;
                    two_nxt   = rd_two;
                    z1_nxt    = rs1_zero;
                    z2_nxt    = rd_two && rs2_zero;
                    state_nxt = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                state_nxt = IDLE;
            end
            RD_ISSUE: begin
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end else begin
                    rsp_valid_nxt = 1'b1;
                end
            end
        endcase
        wr_ready_nxt = (state_nxt == IDLE) && !wr_fire && !rd_fire
                       && grant_wr;
        rd_ready_nxt = (state_nxt == IDLE) && !wr_fire && !rd_fire
                       && grant_rd;
    end

    // State and registered outputs; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rf_cmd    <= RF_CMD_HOLD;
            rf_port1  <= '0;
            rf_port2  <= '0;
            rsp_valid <= 1'b0;
            wr_ready  <= 1'b0;
            rd_ready  <= 1'b0;
            two_q     <= 1'b0;
            z1_q      <= 1'b0;
            z2_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rf_cmd    <= cmd_nxt;
            rf_port1  <= p1_nxt;
            rf_port2  <= p2_nxt;
            rsp_valid <= rsp_valid_nxt;
            wr_ready  <= wr_ready_nxt;
            rd_ready  <= rd_ready_nxt;
            two_q     <= two_nxt;
            z1_q      <= z1_nxt;
            z2_q      <= z2_nxt;
        end
    end

    // The file holds its latches under HOLD, so the response mirrors them
    assign rsp_data1 = z1_q ? '0 : rf_out1;
    assign rsp_data2 = (!two_q || z2_q) ? '0 : rf_out2;

endmodule
